// File: rtl/seq_decoder_pkg.sv
// seq_decoder_pkg
//   Shared types and helpers for the sequenced one-hot decoder.
//   - state_t     : controller state (IDLE / HOLD / SCAN)
//   - timer_width : bits needed to count up to max(HOLD_CYCLES, DWELL)
//   Optional feature macro used by seq_decoder: SEQ_DEC_RANGE_CHK_EN.
package seq_decoder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_SCAN = 2'd2
  } state_t;

  // clog2(max(hold_cycles, dwell) + 1), never below one bit.
  function automatic int timer_width(input int hold_cycles, input int dwell);
    int m;
    m = (hold_cycles > dwell) ? hold_cycles : dwell;
    return ($clog2(m + 1) < 1) ? 1 : $clog2(m + 1);
  endfunction

endpackage

// File: rtl/seq_decoder_onehot.sv
// seq_decoder_onehot
//   Combinational binary -> one-hot converter with a range flag.
//   Ports:
//     sel      in  SEL_W    binary line index
//     onehot   out NUM_OUT  1<<sel, all-zero when sel >= NUM_OUT
//     in_range out 1        sel < NUM_OUT
module seq_decoder_onehot
  import seq_decoder_pkg::*;
#(
  parameter int SEL_W   = 3,
  parameter int NUM_OUT = 8
) (
  input  logic [SEL_W-1:0]   sel,
  output logic [NUM_OUT-1:0] onehot,
  output logic               in_range
);

  // One extra bit so NUM_OUT == 2**SEL_W still compares correctly.
  assign in_range = ({1'b0, sel} < (SEL_W + 1)'(NUM_OUT));

  for (genvar gi = 0; gi < NUM_OUT; gi++) begin : g_line
    assign onehot[gi] = (sel == SEL_W'(gi));
  end

endmodule

// File: rtl/seq_decoder.sv
// seq_decoder
//   Registered one-hot decoder with a valid/ready select port, optional
//   timed hold and an autonomous SCAN mode that walks the active line.
//   Ports:
//     clk, rst     clock, synchronous active-high reset
//     sel          line to assert; sel_valid / sel_ready handshake
//     clear        drop any line, go IDLE
//     scan_start   enter SCAN (from IDLE/HOLD); scan_stop leaves SCAN
//     y            registered zero-or-one-hot output
//     busy         high while in SCAN
//     err          one-cycle out-of-range pulse
//   Macro SEQ_DEC_RANGE_CHK_EN: when defined an out-of-range transfer leaves
//   y/state/timer untouched and pulses err; otherwise it clears y (err = 0).
module seq_decoder
  import seq_decoder_pkg::*;
#(
  parameter int SEL_W       = 3,
  parameter int NUM_OUT     = 8,
  parameter int HOLD_CYCLES = 0,
  parameter int DWELL       = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [SEL_W-1:0]   sel,
  input  logic               sel_valid,
  output logic               sel_ready,
  input  logic               clear,
  input  logic               scan_start,
  input  logic               scan_stop,
  output logic [NUM_OUT-1:0] y,
  output logic               busy,
  output logic               err
);

  localparam int                 TIMER_W    = timer_width(HOLD_CYCLES, DWELL);
  localparam logic [TIMER_W-1:0] HOLD_LOAD  = TIMER_W'(HOLD_CYCLES);
  localparam logic [TIMER_W-1:0] DWELL_LOAD = TIMER_W'(DWELL - 1);
  localparam logic [SEL_W-1:0]   LAST_IDX   = SEL_W'(NUM_OUT - 1);
  localparam bit                 HOLD_TIMED = (HOLD_CYCLES > 0);

  state_t               state_reg, state_next;
  logic [NUM_OUT-1:0]   y_reg, y_next;
  logic [TIMER_W-1:0]   timer_reg, timer_next;
  logic [SEL_W-1:0]     idx_reg, idx_next;

  logic [NUM_OUT-1:0]   cmd_onehot, scan_onehot;
  logic                 cmd_in_range, scan_in_range;
  logic [SEL_W-1:0]     scan_idx_adv;
  logic                 transfer;

  // Ready already excludes clear/scan_start/SCAN, which gives those the
  // required priority over a select transfer.
  assign sel_ready    = (state_reg != ST_SCAN) & ~scan_start & ~clear;
  assign transfer     = sel_valid & sel_ready;
  assign scan_idx_adv = (idx_reg == LAST_IDX) ? '0 : idx_reg + 1'b1;

  seq_decoder_onehot #(.SEL_W(SEL_W), .NUM_OUT(NUM_OUT)) u_cmd_dec (
    .sel      (sel),
    .onehot   (cmd_onehot),
    .in_range (cmd_in_range)
  );

  // Decodes the line the scan will move to at the next dwell expiry.
  seq_decoder_onehot #(.SEL_W(SEL_W), .NUM_OUT(NUM_OUT)) u_scan_dec (
    .sel      (scan_idx_adv),
    .onehot   (scan_onehot),
    .in_range (scan_in_range)
  );

`ifdef SEQ_DEC_RANGE_CHK_EN
  logic err_reg, err_next;
`endif

  always_comb begin
    state_next = state_reg;
    y_next     = y_reg;
    timer_next = timer_reg;
    idx_next   = idx_reg;
`ifdef SEQ_DEC_RANGE_CHK_EN
    err_next   = 1'b0;
`endif
    if (clear) begin
      state_next = ST_IDLE;
      y_next     = '0;
      timer_next = '0;
      idx_next   = '0;
    end else if (state_reg == ST_SCAN) begin
      if (scan_stop) begin
        state_next = ST_IDLE;
        y_next     = '0;
        timer_next = '0;
        idx_next   = '0;
      end else if (timer_reg == '0) begin
        idx_next   = scan_idx_adv;
        y_next     = scan_onehot & {NUM_OUT{scan_in_range}};
        timer_next = DWELL_LOAD;
      end else begin
        timer_next = timer_reg - 1'b1;
      end
    end else if (scan_start) begin
      state_next = ST_SCAN;
      y_next     = NUM_OUT'(1);
      idx_next   = '0;
      timer_next = DWELL_LOAD;
    end else if (transfer) begin
      if (cmd_in_range) begin
        state_next = ST_HOLD;
        y_next     = cmd_onehot;
        timer_next = HOLD_LOAD;
      end else begin
`ifdef SEQ_DEC_RANGE_CHK_EN
        err_next   = 1'b1;
`else
        state_next = ST_IDLE;
        y_next     = '0;
        timer_next = '0;
`endif
      end
    end else if (HOLD_TIMED && state_reg == ST_HOLD) begin
      // Timer holds the number of high cycles still to come, including this one.
      if (timer_reg <= TIMER_W'(1)) begin
        state_next = ST_IDLE;
        y_next     = '0;
        timer_next = '0;
      end else begin
        timer_next = timer_reg - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      y_reg     <= '0;
      timer_reg <= '0;
      idx_reg   <= '0;
    end else begin
      state_reg <= state_next;
      y_reg     <= y_next;
      timer_reg <= timer_next;
      idx_reg   <= idx_next;
    end
  end

`ifdef SEQ_DEC_RANGE_CHK_EN
  always_ff @(posedge clk) begin
    if (rst) err_reg <= 1'b0;
    else     err_reg <= err_next;
  end
  assign err = err_reg;
`else
  assign err = 1'b0;
`endif

  assign y    = y_reg;
  assign busy = (state_reg == ST_SCAN);

endmodule
